// File: rtl/riscv_fpga_top_pkg.sv
// Shared definitions for the DE1-SoC bring-up top: clock-mode encodings,
// counter width, push-button indices and the LED byte selector.
package fpga_top_pkg;

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_MED  = 2'b10,
        MODE_FULL = 2'b11
    } mode_e;

    localparam int unsigned CNT_W = 32;

    localparam int unsigned KEY_RST    = 0;
    localparam int unsigned KEY_LOAD_A = 1;
    localparam int unsigned KEY_LOAD_B = 2;
    localparam int unsigned KEY_STEP   = 3;

    function automatic logic [7:0] byte_sel(input logic [CNT_W-1:0] value,
                                            input logic [1:0]       sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = value[7:0];
            2'd1:    b = value[15:8];
            2'd2:    b = value[23:16];
            default: b = value[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/riscv_fpga_top_if.sv
// Board pin bundle of the bring-up top: buttons and switches in, red LEDs out.
// master drives the buttons/switches (board or bench), slave is the design side.
interface riscv_fpga_top_if;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;

    modport master (output key, output sw, input ledr);
    modport slave  (input key, input sw, output ledr);
endinterface

// File: rtl/riscv_fpga_top_key_conditioner.sv
// One active-low push-button: 2-flop synchronizer, optional stability filter
// (KEY_DEBOUNCE_EN), and a previous-level register producing a press edge.
module key_conditioner
    import fpga_top_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed,
    output logic press_edge
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic level;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    // Synchronizer resets to the released (high) pin level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_level_q, db_level_d;

    // Count consecutive cycles the synchronized level disagrees with the output.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        if (~sync2_q != db_level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
        end
    end

    assign level = db_level_q;
`else
    localparam int unsigned db_cycles_unused = DEBOUNCE_CYCLES;

    assign level = ~sync2_q;
`endif

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pressed    = level;
    assign press_edge = level & ~prev_q;

endmodule

// File: rtl/riscv_fpga_top.sv
// DE1-SoC bring-up top: KEY[0] reset synchronizer, three conditioned buttons,
// mode register, free-running prescaler and 32-bit step counter shown on LEDR.
// Optional button debounce is compiled in with KEY_DEBOUNCE_EN.
module riscv_fpga_top
    import fpga_top_pkg::*;
#(
    parameter int unsigned DIV_SLOW        = 22,
    parameter int unsigned DIV_MED         = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);

    logic key_rst;
    logic rst_meta_q, rst_meta_d;
    logic rst_q, rst_d;
    logic rst;

    assign key_rst = ~KEY[KEY_RST];

    always_comb begin
        rst_meta_d = 1'b0;
        rst_d      = rst_meta_q;
    end

    // Asserts as soon as KEY[0] drops, releases on the 2nd edge after it rises.
    always_ff @(posedge CLOCK_50 or posedge key_rst) begin
        if (key_rst) begin
            rst_meta_q <= 1'b1;
            rst_q      <= 1'b1;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_q      <= rst_d;
        end
    end

    assign rst = rst_q;

    logic [3:1] key_pressed;
    logic [3:1] key_edge;

    for (genvar i = 1; i <= 3; i++) begin : g_key
        key_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk       (CLOCK_50),
            .rst       (rst),
            .key_n     (KEY[i]),
            .pressed   (key_pressed[i]),
            .press_edge(key_edge[i])
        );
    end

    // The chord is new exactly when both keys are held and at least one of them
    // was not held last cycle, so the per-key history doubles as chord history.
    logic chord_edge;
    assign chord_edge = key_pressed[KEY_LOAD_A] & key_pressed[KEY_LOAD_B]
                      & (key_edge[KEY_LOAD_A] | key_edge[KEY_LOAD_B]);

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    // The tick uses the mode held this cycle, so a step arriving with a chord
    // only counts when the mode was already halted.
    always_comb begin
        tick = 1'b0;
        case (mode_q)
            MODE_HALT: tick = key_edge[KEY_STEP];
            MODE_SLOW: tick = &presc_q[DIV_SLOW-1:0];
            MODE_MED:  tick = &presc_q[DIV_MED-1:0];
            MODE_FULL: tick = 1'b1;
            default:   tick = 1'b0;
        endcase
    end

    always_comb begin
        mode_d  = chord_edge ? mode_e'(SW[1:0]) : mode_q;
        presc_d = presc_q + CNT_W'(1);
        cnt_d   = tick ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_HALT;
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    logic sw_unused;
    assign sw_unused = ^SW[7:2];

    always_comb begin
        LEDR = {mode_q, byte_sel(cnt_q, SW[9:8])};
    end

endmodule

// File: tb/tb_riscv_fpga_top.sv
// Directed bench for riscv_fpga_top: expected LEDR values are queued by the
// stimulus and compared by a negedge monitor.
module tb_riscv_fpga_top;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  riscv_fpga_top_if pins();

  riscv_fpga_top #(
    .DIV_SLOW       (6),
    .DIV_MED        (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (pins.key),
    .SW      (pins.sw),
    .LEDR    (pins.ledr)
  );

  logic [9:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [9:0] mon_exp;
  string      mon_name;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      checks++;
      if (pins.ledr !== mon_exp) begin
        errors++;
        $display("FAIL %s: LEDR=%h expected %h at %0t", mon_name, pins.ledr, mon_exp, $time);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish by %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_led(input string name, input logic [9:0] value);
    exp_q.push_back(value);
    name_q.push_back(name);
  endtask

  task automatic do_reset();
    pins.key = 4'b1110;
    cyc(3);
    pins.key = 4'b1111;
    cyc(4);
  endtask

  initial begin
    logic [7:0] mv;
    pins.key = 4'b1110;
    pins.sw  = '0;
    cyc(10);
    checks++;
    if (pins.ledr !== 10'h000) begin
      errors++;
      $display("FAIL reset_state: LEDR=%h expected 000 at %0t", pins.ledr, $time);
    end
    expect_led("reset_led", 10'h000);
    cyc(1);
    pins.key = 4'b1111;
    cyc(5);
    expect_led("idle_after_release", 10'h000);
    cyc(1);

    // chord load of mode 11, then free counting
    pins.sw  = 10'b00_0000_0011;
    pins.key = 4'b1001;
    cyc(2);
    pins.key = 4'b1111;
    expect_led("chord_not_yet", 10'h000);
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      expect_led("full_count", {2'b11, 8'(i)});
      cyc(1);
    end

    // reset mid-run for 10 cycles
    pins.key = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      expect_led("reset_mid_hold", 10'h000);
      cyc(1);
    end
    pins.key = 4'b1111;
    cyc(4);
    expect_led("frozen_after_reset", 10'h000);
    cyc(5);
    expect_led("still_frozen", 10'h000);
    cyc(1);

    pins.key = 4'b1001;
    cyc(2);
    pins.key = 4'b1111;
    expect_led("rechord_not_yet", 10'h000);
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      expect_led("restart_count", {2'b11, 8'(i)});
      cyc(1);
    end

    // manual steps in mode 00
    do_reset();
    pins.sw = '0;
    for (int i = 1; i <= 3; i++) begin
      pins.key = 4'b0111;
      cyc(2);
      pins.key = 4'b1111;
      expect_led("step_latency", {2'b00, 8'(i - 1)});
      cyc(1);
      expect_led("step_count", {2'b00, 8'(i)});
      cyc(3);
    end
    expect_led("step_total", 10'h003);
    cyc(1);

    // step key held through reset release gives one step
    pins.key = 4'b0110;
    cyc(3);
    pins.key = 4'b0111;
    cyc(2);
    expect_led("held_in_reset", 10'h000);
    cyc(3);
    expect_led("held_release_edge", 10'h001);
    cyc(1);
    pins.key = 4'b1111;
    cyc(4);
    expect_led("held_single_step", 10'h001);
    cyc(1);

    // byte select and wrap
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    for (int s = 0; s < 4; s++) begin
      pins.sw = {2'(s), 6'b0, 2'b11};
      expect_led("byte_select", (s == 0) ? 10'h0FE : 10'h0FF);
      cyc(1);
    end
    pins.key = 4'b1001;
    cyc(2);
    pins.key = 4'b1111;
    expect_led("wrap_pre_load", 10'h0FF);
    cyc(1);
    expect_led("wrap_fffffffe", 10'h3FF);
    cyc(1);
    expect_led("wrap_ffffffff", 10'h3FF);
    cyc(1);
    expect_led("wrap_zero", 10'h300);
    cyc(1);
    pins.sw = 10'b00_0000_0011;
    expect_led("after_wrap_low", 10'h301);
    cyc(1);

    // chord and step in the same cycle while halted
    do_reset();
    pins.sw  = 10'b00_0000_0011;
    pins.key = 4'b0001;
    cyc(2);
    pins.key = 4'b1111;
    expect_led("combo_pre", 10'h000);
    cyc(1);
    expect_led("combo_step_and_load", 10'h301);
    cyc(1);
    expect_led("combo_next", 10'h302);
    cyc(1);

    // medium divider, 2^4 cycles per tick
    do_reset();
    pins.sw  = 10'b00_0000_0010;
    pins.key = 4'b1001;
    cyc(2);
    pins.key = 4'b1111;
    cyc(1);
    for (int k = 7; k <= 40; k++) begin
      mv = (k >= 34) ? 8'd2 : (k >= 18) ? 8'd1 : 8'd0;
      expect_led("med_divider", {2'b10, mv});
      cyc(1);
    end

    cyc(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: %0d expected values never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule

// File: doc/riscv_fpga_top.md
# riscv_fpga_top

Board-level top for the DE1-SoC bring-up build. Conditions the push-buttons and derives an internal reset, generates a selectable-rate step tick from the 50 MHz clock, and runs a 32-bit step counter. The counter and current clock mode are shown on the red LEDs. It sits directly under the pin assignments; optional peripheral pin groups (`USE_ADC`, `USE_VIDEO`, …) are outside this block's scope and are not part of its behaviour.

## Interface
- `DIV_SLOW`, 22: prescaler exponent for slow mode; tick every 2^22 cycles.
- `DIV_MED`, 16: prescaler exponent for medium mode; tick every 2^16 cycles.
- `DEBOUNCE_CYCLES`, 500000: stable-sample count, used only when debounce is compiled in.
- `CLOCK_50` in 1: the single clock; all logic on the rising edge.
- `KEY` in 4: push-buttons, active-low.
  - `KEY[0]` is the reset: internal `reset = ~KEY[0]`, asynchronous and active-high.
  - `KEY[1]` + `KEY[2]` pressed together form the mode-load chord.
  - `KEY[3]` is the manual step.
- `SW` in 10: slide switches.
  - `SW[1:0]` is the mode to load.
  - `SW[9:8]` selects which counter byte is displayed.
  - `SW[7:2]` are unused.
- `LEDR` out 10:
  - `LEDR[7:0]` = selected byte of the step counter.
  - `LEDR[9:8]` = current mode.

## Operation
- **Reset.**
  - Asserts asynchronously; deasserts through a 2-flop synchronizer, so it releases on the 2nd rising edge after `KEY[0]` returns high.
  - Reset values: mode = 00, prescaler = 0, step counter = 0, key synchronizers = released, edge-history = released.
  - Resulting outputs: `LEDR` = 0.
- **Key conditioning.** `KEY[3:1]` each pass through a 2-flop synchronizer, inverted to "pressed".
- **Mode load.**
  - `chord` = pressed1 & pressed2.
  - On a chord rising edge (chord now, no chord in the previous cycle), mode <= `SW[1:0]`.
- **Modes.**
  - 00: halted. A rising press edge on `KEY[3]` gives exactly one tick.
  - 01: tick when the prescaler's low `DIV_SLOW` bits are all ones.
  - 10: same rule using `DIV_MED` bits.
  - 11: tick every cycle.
- **Prescaler.**
  - 32-bit, free-running, increments every cycle, wraps.
  - Not cleared on a mode change.
- **Step counter.** 32-bit; increments by 1 on each tick; wraps from 0xFFFFFFFF to 0.
- **Display.** `LEDR[7:0]` = counter[8*`SW[9:8]` +: 8]. `LEDR` is combinational from registers and `SW`.
- **Boundary cases.**
  - A chord edge and a `KEY[3]` edge in the same cycle: the mode loads. The step is honoured only if the mode was already 00 in that cycle.
  - A key held through reset release produces a press edge once synchronized.
  - Reset mid-count clears everything immediately.

## Timing
- Key latency:
  - A pin sampled low at edge 1 appears in the synchronizer output at edge 2.
  - The mode register loads at edge 3.
  - `LEDR[9:8]` shows the new mode after edge 3.
- After mode becomes 11, the counter's first increment is at the next edge. It then increments every cycle.
- The manual step in mode 00 updates the counter 3 edges after the press is sampled.
- Sampling requirement: presses of at least 2 clock cycles (40 ns) are guaranteed to register without debounce.

## Configuration
- `KEY_DEBOUNCE_EN` defined:
  - Each synchronized key (`KEY[3:1]`) must remain stable for `DEBOUNCE_CYCLES` consecutive cycles before its conditioned level changes.
  - Latency grows by `DEBOUNCE_CYCLES`.
  - `KEY[0]`/reset is never debounced.
- Undefined: no debounce; timing exactly as above.

## Structure
- Package `fpga_top_pkg`:
  - mode encodings `MODE_HALT`/`MODE_SLOW`/`MODE_MED`/`MODE_FULL`
  - counter width (32)
  - key index constants
- Sub-module `key_conditioner`:
  - one per key
  - synchronizer, optional debounce and previous-level register
  - outputs `pressed` and `press_edge`
- Instantiated 3 times in the top.

## Test plan
- **Reset from idle.** `KEY`=1110 for 10 cycles → `LEDR`=0. After release, `LEDR` stays 0 (mode 00, no ticks).
- **Chord load.** `SW`=0000000011, `KEY`=1001 for 2 cycles after reset release → mode=11 by the 3rd edge. The counter then increments every cycle; with `SW[9:8]`=00, `LEDR[7:0]` counts 1, 2, 3…
- **Reset mid-run.** With mode 11 running, `KEY`=1110 for 200 ns → `LEDR` goes to 0 immediately and holds. After release, the mode is 00 and the counter is frozen. A second 1001 chord restarts counting from 0.
- **Manual step.** Mode 00, pulse `KEY[3]` low three times, each 2 cycles → counter = 3, `LEDR[7:0]`=0x03.
- **Byte select and wrap.** Force the counter to 0xFFFFFFFE in mode 11 → after 2 cycles the counter = 0. Check `SW[9:8]`=11 shows 0xFF before the wrap and 0x00 after.
- **Medium divider.** With `DIV_MED`=4, mode 10 → exactly one tick per 16 cycles.
